// File: rtl/mmio_bridge_pkg.sv
// Shared types and sizes for the host MMIO status bridge.
package mmio_bridge_pkg;

  typedef enum logic [1:0] {
    OP_PUSH  = 2'b00,
    OP_PROBE = 2'b01,
    OP_PAGE  = 2'b10,
    OP_CLEAR = 2'b11
  } mmio_op_e;

  localparam int unsigned PAGE_W    = 29;
  localparam int unsigned CMD_W     = 30;
  localparam int unsigned MAX_PAGES = 4;
  localparam int unsigned STICKY_W  = PAGE_W * MAX_PAGES;

  typedef struct packed {
    logic              overflow;
    logic [1:0]        page;
    logic [PAGE_W-1:0] sticky;
  } status_word_t;

endpackage

// File: rtl/mmio_cmd_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted only alongside a pop.
module mmio_cmd_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 30
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    drop_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop_c  = push && full && !do_pop;
  // Head reads zero while empty so the consumer never sees stale data.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mmio_status_bridge.sv
// Host MMIO front-end: command FIFO, paged sticky done status, change-triggered notify.
// Optional PROBE status snapshot enabled by `define MMIO_STATUS_BRIDGE_PROBE_EN.
module mmio_status_bridge
  import mmio_bridge_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned NUM_DONE   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  h2f_pio32,
  input  logic                         h2f_write,
  output logic [31:0]                  f2h_pio32,
  output logic                         f2h_write,
  output logic [CMD_W-1:0]             cmd_data,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  input  logic [NUM_DONE-1:0]          done_in,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  mmio_op_e          op;
  logic [CMD_W-1:0]  payload;
  logic              fifo_empty;
  logic              fifo_drop;

  logic [NUM_DONE-1:0] sticky;
  logic [NUM_DONE-1:0] sticky_next;
  logic [NUM_DONE-1:0] clear_mask;
  logic [STICKY_W-1:0] sticky_wide;
  logic [1:0]          page;
  logic [1:0]          page_next;
  logic                overflow;
  logic                overflow_next;
  status_word_t        normal_word;
  logic [31:0]         word_next;

  assign op        = mmio_op_e'(h2f_pio32[31:30]);
  assign payload   = h2f_pio32[29:0];
  assign cmd_valid = !fifo_empty;

  mmio_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (h2f_write && (op == OP_PUSH)),
    .push_data (payload),
    .pop       (cmd_ready),
    .head      (cmd_data),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .drop_c    (fifo_drop)
  );

  // Next-state of sticky bits, page, overflow and the normal status word.
  always_comb begin
    clear_mask    = '0;
    page_next     = page;
    overflow_next = overflow;
    if (h2f_write && (op == OP_CLEAR)) begin
      clear_mask = NUM_DONE'(STICKY_W'(payload[PAGE_W-1:0]) << (32'(page) * PAGE_W));
      if (payload[29]) overflow_next = 1'b0;
    end
    if (h2f_write && (op == OP_PAGE)) page_next = payload[1:0];
    if (fifo_drop) overflow_next = 1'b1;
    // Set after clear so a same-cycle done pulse wins.
    sticky_next          = (sticky & ~clear_mask) | done_in;
    sticky_wide          = STICKY_W'(sticky_next);
    normal_word.overflow = overflow_next;
    normal_word.page     = page_next;
    normal_word.sticky   = sticky_wide[32'(page_next) * PAGE_W +: PAGE_W];
  end

`ifdef MMIO_STATUS_BRIDGE_PROBE_EN
  typedef enum logic {ST_NORMAL, ST_PROBE} state_e;

  state_e      state;
  state_e      state_next;
  logic        probe_cmd;
  logic [31:0] probe_word;

  assign probe_cmd  = h2f_write && (op == OP_PROBE);
  assign probe_word = {1'b1, 7'h0, 8'(FIFO_DEPTH - 1), 7'h0, 9'(fifo_level)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_NORMAL;
    else     state <= state_next;
  end

  // A PROBE while already probing re-arms for one more cycle.
  always_comb begin
    state_next = ST_NORMAL;
    word_next  = normal_word;
    case (state)
      ST_NORMAL: if (probe_cmd) state_next = ST_PROBE;
      ST_PROBE:  if (probe_cmd) state_next = ST_PROBE;
      default:   state_next = ST_NORMAL;
    endcase
    if (state_next == ST_PROBE) word_next = probe_word;
  end
`else
  assign word_next = normal_word;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky    <= '0;
      page      <= '0;
      overflow  <= 1'b0;
      f2h_pio32 <= '0;
      f2h_write <= 1'b0;
    end else begin
      sticky    <= sticky_next;
      page      <= page_next;
      overflow  <= overflow_next;
      f2h_pio32 <= word_next;
      f2h_write <= (word_next != f2h_pio32);
    end
  end

endmodule

// File: tb/tb_mmio_status_bridge.sv
// Scoreboard bench for mmio_status_bridge (FIFO_DEPTH=16, NUM_DONE=64).
module tb_mmio_status_bridge;

  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned NUM_DONE   = 64;

  logic                        clk;
  logic                        rst;
  logic [31:0]                 h2f_pio32;
  logic                        h2f_write;
  logic [31:0]                 f2h_pio32;
  logic                        f2h_write;
  logic [29:0]                 cmd_data;
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [NUM_DONE-1:0]         done_in;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_f2h[$];
  logic [29:0] exp_cmd[$];
  logic [31:0] exp_word;

  mmio_status_bridge #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .NUM_DONE   (NUM_DONE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .h2f_pio32  (h2f_pio32),
    .h2f_write  (h2f_write),
    .f2h_pio32  (f2h_pio32),
    .f2h_write  (f2h_write),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .done_in    (done_in),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every notify pulse and every accepted pop consumes one expectation.
  always @(negedge clk) begin
    if (f2h_write) begin
      if (exp_f2h.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL f2h_write: unexpected pulse with f2h_pio32=0x%08h", f2h_pio32);
      end else begin
        exp_word = exp_f2h.pop_front();
        check("f2h_pio32 on pulse", f2h_pio32, exp_word);
      end
    end
    if (cmd_valid && cmd_ready) begin
      if (exp_cmd.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL cmd pop: unexpected cmd_data=0x%08h", cmd_data);
      end else begin
        exp_word = 32'(exp_cmd.pop_front());
        check("cmd_data on pop", 32'(cmd_data), exp_word);
      end
    end
  end

  task automatic cycle(input logic wr, input logic [31:0] word, input logic rdy,
                       input logic [NUM_DONE-1:0] done);
    h2f_write = wr;
    h2f_pio32 = word;
    cmd_ready = rdy;
    done_in   = done;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, '0);
  endtask

  initial begin
    rst       = 1'b0;
    h2f_write = 1'b0;
    h2f_pio32 = '0;
    cmd_ready = 1'b0;
    done_in   = '0;
    #1 rst = 1'b1;
    #1;
    check("reset f2h_pio32", f2h_pio32, 32'h0);
    check("reset f2h_write", 32'(f2h_write), 32'h0);
    check("reset cmd_valid", 32'(cmd_valid), 32'h0);
    check("reset cmd_data", 32'(cmd_data), 32'h0);
    check("reset fifo_level", 32'(fifo_level), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    idle();

    // Three pushes held, then drained in order.
    for (int i = 1; i <= 3; i++) begin
      exp_cmd.push_back(30'(i));
      cycle(1'b1, {2'b00, 30'(i)}, 1'b0, '0);
    end
    check("level after 3 push", 32'(fifo_level), 32'd3);
    check("head after 3 push", 32'(cmd_data), 32'h1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, '0);
    check("cmd_valid after drain", 32'(cmd_valid), 32'h0);
    idle();

    // Overfill: 17th push is dropped and raises overflow.
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) exp_cmd.push_back(30'(32'h100 + i));
      else        exp_f2h.push_back(32'h8000_0000);
      cycle(1'b1, {2'b00, 30'(32'h100 + i)}, 1'b0, '0);
    end
    check("level when full", 32'(fifo_level), 32'd16);
    check("overflow word", f2h_pio32, 32'h8000_0000);
    // Push while full with a same-cycle pop is accepted.
    for (int i = 0; i < 16; i++) begin
      exp_cmd.push_back(30'(32'h200 + i));
      cycle(1'b1, {2'b00, 30'(32'h200 + i)}, 1'b1, '0);
    end
    check("level after push+pop", 32'(fifo_level), 32'd16);
    check("overflow still set", f2h_pio32, 32'h8000_0000);
    for (int i = 0; i < 16; i++) cycle(1'b0, 32'h0, 1'b1, '0);
    idle();
    check("level after drain", 32'(fifo_level), 32'd0);
    exp_f2h.push_back(32'h0);
    cycle(1'b1, 32'hE000_0000, 1'b0, '0);
    idle();
    check("overflow cleared", f2h_pio32, 32'h0);

    // Sticky paging.
    cycle(1'b0, 32'h0, 1'b0, NUM_DONE'(64'd1 << 40));
    idle();
    check("bit40 hidden on page0", f2h_pio32, 32'h0);
    exp_f2h.push_back(32'h2000_0800);
    cycle(1'b1, 32'h8000_0001, 1'b0, '0);
    idle();
    cycle(1'b1, 32'hC000_0800, 1'b0, NUM_DONE'(64'd1 << 40));
    idle();
    check("set wins over clear", f2h_pio32, 32'h2000_0800);
    exp_f2h.push_back(32'h2000_0000);
    cycle(1'b1, 32'hC000_0800, 1'b0, '0);
    idle();

    // Pages beyond the populated range read zero.
    exp_f2h.push_back(32'h6000_0000);
    cycle(1'b1, 32'h8000_0003, 1'b0, '0);
    idle();
    cycle(1'b0, 32'h0, 1'b0, NUM_DONE'(64'd1 << 63));
    idle();
    check("page3 reads zero", f2h_pio32, 32'h6000_0000);
    exp_f2h.push_back(32'h4000_0020);
    cycle(1'b1, 32'h8000_0002, 1'b0, '0);
    idle();

    // Five queued commands, then PROBE.
    for (int i = 0; i < 5; i++) begin
      exp_cmd.push_back(30'(32'h300 + i));
      cycle(1'b1, {2'b00, 30'(32'h300 + i)}, 1'b0, '0);
    end
    check("level before probe", 32'(fifo_level), 32'd5);
`ifdef MMIO_STATUS_BRIDGE_PROBE_EN
    exp_f2h.push_back(32'h800F_0005);
    exp_f2h.push_back(32'h4000_0020);
    cycle(1'b1, 32'h4000_0000, 1'b0, '0);
    check("probe word", f2h_pio32, 32'h800F_0005);
    idle();
    check("word after probe", f2h_pio32, 32'h4000_0020);
`else
    cycle(1'b1, 32'h4000_0000, 1'b0, '0);
    idle();
    check("probe ignored", f2h_pio32, 32'h4000_0020);
`endif
    idle();

    // Asynchronous reset mid-cycle with state pending.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async rst f2h_pio32", f2h_pio32, 32'h0);
    check("async rst f2h_write", 32'(f2h_write), 32'h0);
    check("async rst cmd_valid", 32'(cmd_valid), 32'h0);
    check("async rst cmd_data", 32'(cmd_data), 32'h0);
    check("async rst fifo_level", 32'(fifo_level), 32'h0);
    exp_cmd.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) idle();
    check("post reset word", f2h_pio32, 32'h0);
    exp_f2h.push_back(32'h4000_0000);
    cycle(1'b1, 32'h8000_0002, 1'b0, '0);
    idle();
    idle();

    check("pending f2h expectations", 32'(exp_f2h.size()), 32'd0);
    check("pending cmd expectations", 32'(exp_cmd.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
